// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the mem_ctrl request/acknowledge front end.
// Contents: the FSM state encoding and the default bank geometry.
package mem_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester <-> controller bundle.
//   master (requester): drives req, we, addr, wdata; sees busy, ack, rvalid, rdata, err
//   slave  (mem_ctrl) : the reverse
interface mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) ();

  logic             req;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             ack;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;
  logic             err;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rvalid, rdata, err
  );

endinterface

// File: rtl/mem_word.sv
// mem_word: one WIDTH-bit storage word of the bank.
//   clk   : system clock
//   clear : asynchronous active-high reset, forces q to 0
//   sel   : word select from the address decode
//   wr    : write enable, qualified by sel
//   d     : write data
//   q     : stored word
module mem_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sel,
  input  logic             wr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (sel && wr) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding request/acknowledge controller in front of a
// DEPTH x WIDTH bank of mem_word instances, with a per-word "written" flag.
//   clk   : system clock
//   clear : asynchronous active-high reset (FSM, bank, flags, rdata)
//   bus   : mem_ctrl_if slave modport (req/we/addr/wdata in,
//           busy/ack/rvalid/rdata/err out)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for req; request fields latched on acceptance
//   ACCESS | one cycle: word select active, write or read the bank
//   RESP   | one cycle: ack (plus rvalid on reads, err if flagged)
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic       clk,
  input logic       clear,
  mem_ctrl_if.slave bus
);

  // DEPTH may equal 2^AW, so the range compare needs one extra bit.
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic             we_l_q;
  logic [AW-1:0]    addr_l_q;
  logic [WIDTH-1:0] wdata_l_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic [DEPTH-1:0] written_q;

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] sel;
  logic [WIDTH-1:0] hit_word;
  logic             hit_written;
  logic             in_range;
  logic             accept;

  assign accept   = (state_q == IDLE) && bus.req;
  assign in_range = {1'b0, addr_l_q} < DEPTH_L;

  // Address decode: only in-range words can match, so an out-of-range
  // address leaves sel all-zero and hit_word/hit_written at 0.
  always_comb begin
    sel         = '0;
    hit_word    = '0;
    hit_written = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_l_q == AW'(i)) begin
        sel[i]      = (state_q == ACCESS);
        hit_word    = word_q[i];
        hit_written = written_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      we_l_q    <= 1'b0;
      addr_l_q  <= '0;
      wdata_l_q <= '0;
    end else if (accept) begin
      we_l_q    <= bus.we;
      addr_l_q  <= bus.addr;
      wdata_l_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= !in_range || (!we_l_q && !hit_written);
      if (!we_l_q) begin
        rdata_q <= hit_written ? hit_word : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      written_q <= '0;
    end else if ((state_q == ACCESS) && we_l_q) begin
      written_q <= written_q | sel;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    mem_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .clear (clear),
      .sel   (sel[g]),
      .wr    (we_l_q),
      .d     (wdata_l_q),
      .q     (word_q[g])
    );
  end

  // Response flags are gated by RESP so they are single-cycle by construction.
  assign bus.busy   = (state_q != IDLE);
  assign bus.ack    = (state_q == RESP);
  assign bus.rvalid = (state_q == RESP) && !we_l_q;
  assign bus.err    = (state_q == RESP) && err_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_pkg::*;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.WIDTH(16), .AW(2)) b4 ();
  mem_ctrl_if #(.WIDTH(16), .AW(2)) b3 ();

  logic        req_s   = 1'b0;
  logic        we_s    = 1'b0;
  logic        tgt3    = 1'b0;
  logic [1:0]  addr_s  = 2'd0;
  logic [15:0] wdata_s = 16'h0;

  assign b4.req   = req_s & ~tgt3;
  assign b3.req   = req_s & tgt3;
  assign b4.we    = we_s;
  assign b3.we    = we_s;
  assign b4.addr  = addr_s;
  assign b3.addr  = addr_s;
  assign b4.wdata = wdata_s;
  assign b3.wdata = wdata_s;

  mem_ctrl #(.WIDTH(16), .DEPTH(4), .AW(2)) dut4 (.clk(clk), .clear(clear), .bus(b4));
  mem_ctrl #(.WIDTH(16), .DEPTH(3), .AW(2)) dut3 (.clk(clk), .clear(clear), .bus(b3));

  logic        ack_m, busy_m, rvalid_m, err_m;
  logic [15:0] rdata_m;
  assign ack_m    = tgt3 ? b3.ack    : b4.ack;
  assign busy_m   = tgt3 ? b3.busy   : b4.busy;
  assign rvalid_m = tgt3 ? b3.rvalid : b4.rvalid;
  assign err_m    = tgt3 ? b3.err    : b4.err;
  assign rdata_m  = tgt3 ? b3.rdata  : b4.rdata;

  typedef struct {
    logic        rvalid;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    logic        clr;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        xerr;
    logic [15:0] xrdata;
  } vec_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;
  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt4 = 0;
  int ack_cnt3 = 0;
  logic [15:0] hold4 = 16'h0;
  logic [15:0] hold3 = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops one expected response.
  always @(negedge clk) begin
    if (!clear && b4.ack) begin
      ack_cnt4++;
      if (q4.size() == 0) begin
        chk("spurious_ack4", 32'(b4.ack), 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("rvalid4", 32'(b4.rvalid), 32'(e4.rvalid));
        chk("err4", 32'(b4.err), 32'(e4.err));
        chk("rdata4", 32'(b4.rdata), 32'(e4.rdata));
      end
    end
    if (!clear && b3.ack) begin
      ack_cnt3++;
      if (q3.size() == 0) begin
        chk("spurious_ack3", 32'(b3.ack), 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("rvalid3", 32'(b3.rvalid), 32'(e3.rvalid));
        chk("err3", 32'(b3.err), 32'(e3.err));
        chk("rdata3", 32'(b3.rdata), 32'(e3.rdata));
      end
    end
  end

  task automatic push_exp(input logic t3, input logic w, input logic xerr, input logic [15:0] xrd,
                          output logic [15:0] hold);
    exp_t e;
    hold = t3 ? hold3 : hold4;
    if (!w) hold = xrd;
    e.rvalid = !w;
    e.err    = xerr;
    e.rdata  = hold;
    if (t3) begin
      q3.push_back(e);
      hold3 = hold;
    end else begin
      q4.push_back(e);
      hold4 = hold;
    end
  endtask

  task automatic do_txn(input logic t3, input logic w, input logic [1:0] a, input logic [15:0] d,
                        input logic xerr, input logic [15:0] xrd);
    logic [15:0] hold;
    @(negedge clk);
    tgt3 = t3; req_s = 1'b1; we_s = w; addr_s = a; wdata_s = d;
    push_exp(t3, w, xerr, xrd, hold);
    @(posedge clk);
    @(negedge clk);
    req_s = 1'b0; we_s = ~w; addr_s = ~a; wdata_s = ~d;
    chk("busy_access", 32'(busy_m), 32'd1);
    chk("ack_early", 32'(ack_m), 32'd0);
    @(negedge clk);
    chk("ack_latency", 32'(ack_m), 32'd1);
    chk("busy_resp", 32'(busy_m), 32'd1);
    @(negedge clk);
    chk("ack_width", 32'(ack_m), 32'd0);
    chk("rvalid_width", 32'(rvalid_m), 32'd0);
    chk("err_width", 32'(err_m), 32'd0);
    chk("busy_idle", 32'(busy_m), 32'd0);
    chk("rdata_hold", 32'(rdata_m), 32'(hold));
  endtask

  task automatic check_cleared();
    chk("clr_busy", 32'({b4.busy, b3.busy}), 32'd0);
    chk("clr_ack", 32'({b4.ack, b3.ack}), 32'd0);
    chk("clr_rvalid", 32'({b4.rvalid, b3.rvalid}), 32'd0);
    chk("clr_err", 32'({b4.err, b3.err}), 32'd0);
    chk("clr_rdata4", 32'(b4.rdata), 32'd0);
    chk("clr_rdata3", 32'(b3.rdata), 32'd0);
    chk("clr_state4", 32'(dut4.state_q), 32'(ST_IDLE));
    chk("clr_state3", 32'(dut3.state_q), 32'(ST_IDLE));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    #1 clear = 1'b1;
    #1 check_cleared();
    #2 clear = 1'b0;
    hold4 = 16'h0;
    hold3 = 16'h0;
  endtask

  function automatic logic [15:0] b2b_word(input logic [1:0] a);
    case (a)
      2'd0:    return 16'h1111;
      2'd2:    return 16'h2222;
      default: return 16'h0000;
    endcase
  endfunction

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 16'hA5C3, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 16'h0000, 1'b0, 16'hA5C3};
    tbl[3] = '{1'b1, 1'b1, 2'd0, 16'h1111, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 16'h2222, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 16'h1111};
    tbl[6] = '{1'b0, 1'b0, 2'd1, 16'h0000, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 2'd2, 16'h0000, 1'b0, 16'h2222};
    tbl[8] = '{1'b0, 1'b0, 2'd3, 16'h0000, 1'b1, 16'h0000};

    // Reset held from time 0, checked before any clock edge.
    #3 check_cleared();
    #9 clear = 1'b0;
    pulse_clear();

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].clr) pulse_clear();
      do_txn(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].xerr, tbl[i].xrdata);
    end

    // Back-to-back: req held high, addr changes every cycle; accept every 3rd edge.
    begin
      int ph;
      int acks0;
      logic [15:0] h;
      logic [1:0] a;
      ph = 0;
      acks0 = ack_cnt4;
      @(negedge clk);
      tgt3 = 1'b0; req_s = 1'b1; we_s = 1'b0;
      for (int k = 0; k < 12; k++) begin
        a = 2'(k % 4);
        addr_s = a;
        if (ph == 0) push_exp(1'b0, 1'b0, (a == 2'd1) || (a == 2'd3), b2b_word(a), h);
        @(posedge clk);
        ph = (ph + 1) % 3;
        @(negedge clk);
      end
      req_s = 1'b0;
      chk("b2b_ack_count", 32'(ack_cnt4 - acks0), 32'd4);
      chk("b2b_queue_empty", 32'(q4.size()), 32'd0);
      @(negedge clk);
      chk("b2b_idle", 32'(b4.busy), 32'd0);
    end

    // Clear during ACCESS of a write to addr 2: aborted, no ack, bank cleared.
    begin
      int acks0;
      acks0 = ack_cnt4;
      @(negedge clk);
      tgt3 = 1'b0; req_s = 1'b1; we_s = 1'b1; addr_s = 2'd2; wdata_s = 16'hFFFF;
      @(posedge clk);
      #1 clear = 1'b1;
      req_s = 1'b0;
      #1 chk("midclr_busy", 32'(b4.busy), 32'd0);
      #2 clear = 1'b0;
      hold4 = 16'h0;
      hold3 = 16'h0;
      repeat (4) @(negedge clk);
      chk("midclr_no_ack", 32'(ack_cnt4 - acks0), 32'd0);
      do_txn(1'b0, 1'b0, 2'd2, 16'h0, 1'b1, 16'h0000);
    end

    // DEPTH = 3 instance: addr 3 is out of range.
    do_txn(1'b1, 1'b1, 2'd0, 16'h0AAA, 1'b0, 16'h0);
    do_txn(1'b1, 1'b1, 2'd1, 16'h0BBB, 1'b0, 16'h0);
    do_txn(1'b1, 1'b1, 2'd2, 16'h0CCC, 1'b0, 16'h0);
    do_txn(1'b1, 1'b1, 2'd3, 16'hDDDD, 1'b1, 16'h0);
    do_txn(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0AAA);
    do_txn(1'b1, 1'b0, 2'd1, 16'h0, 1'b0, 16'h0BBB);
    do_txn(1'b1, 1'b0, 2'd2, 16'h0, 1'b0, 16'h0CCC);
    do_txn(1'b1, 1'b0, 2'd3, 16'h0, 1'b1, 16'h0000);

    repeat (3) @(negedge clk);
    chk("final_q4_empty", 32'(q4.size()), 32'd0);
    chk("final_q3_empty", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
